l2_refill_unit: RTL
===================

L2_REFILL_UNIT -- requirements
Module: l2_refill_unit

Interface
- REQ-001: Parameter MEM_LATENCY, default 2, read latency of data memory in cycles; legal range 1..15.
- REQ-002: Parameter CNT_W, default 16, width of statistics counters.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: req_valid  input  1  L2 cache miss request from cache_subsystem_L2.
- REQ-006: req_ready  output  1  unit idle and able to accept a request.
- REQ-007: req_addr  input  32  byte address of missing word.
- REQ-008: req_wb  input  1  victim is dirty and must be written back first.
- REQ-009: req_wb_addr  input  32  byte address of dirty victim.
- REQ-010: req_wb_data  input  32  dirty victim data.
- REQ-011: resp_valid  output  1  refill data available to L2.
- REQ-012: resp_ready  input  1  L2 consumes refill data.
- REQ-013: resp_data  output  32  refill word.
- REQ-014: dmem_addr  output  32  word-aligned data-memory address.
- REQ-015: dmem_we  output  1  one-cycle write strobe.
- REQ-016: dmem_wdata  output  32  write data.
- REQ-017: dmem_re  output  1  one-cycle read strobe.
- REQ-018: dmem_rdata  input  32  read data, valid exactly MEM_LATENCY cycles after the dmem_re cycle.
- REQ-019: refill_cnt, wb_cnt  output  CNT_W each  completed refills / writebacks.

Function
- REQ-020: FSM states SHALL be IDLE, WB, RD, RD_WAIT, RESP.
- REQ-021: req_ready SHALL be 1 only in IDLE; request accepted on edge where req_valid && req_ready.
- REQ-022: On accept, req_addr, req_wb, req_wb_addr, req_wb_data SHALL be registered; inputs ignored until return to IDLE.
- REQ-023: Accept with req_wb=1 -> WB; req_wb=0 -> RD.
- REQ-024: WB: one cycle, dmem_we=1, dmem_addr={wb_addr[31:2],2'b00}, dmem_wdata=wb_data; wb_cnt increments; next RD.
- REQ-025: RD: one cycle, dmem_re=1, dmem_addr={addr[31:2],2'b00}; latency counter loads MEM_LATENCY; next RD_WAIT.
- REQ-026: RD_WAIT: counter decrements each cycle; in the cycle counter==1, dmem_rdata SHALL be captured into resp_data and state goes to RESP.
- REQ-027: RESP: resp_valid=1, resp_data stable until resp_valid && resp_ready; on that edge refill_cnt increments, state -> IDLE.
- REQ-028: Latency accept-edge to first resp_valid cycle SHALL be MEM_LATENCY+2 cycles (no wb), MEM_LATENCY+3 (wb).
- REQ-029: resp_ready held high SHALL complete handshake in first RESP cycle; req_ready rises the next cycle (minimum one idle cycle between requests).
- REQ-030: dmem_we and dmem_re SHALL never be high in the same cycle and each SHALL be high at most one cycle per request.
- REQ-031: dmem_addr SHALL be 0 when neither strobe is active; dmem_wdata 0 outside WB.
- REQ-032: Counters SHALL saturate at all-ones, never wrap.
- REQ-033: req_addr[1:0] and req_wb_addr[1:0] SHALL be ignored (no misalignment error).

Reset
- REQ-034: reset low SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_data=0, dmem_we=0, dmem_re=0, dmem_addr=0, dmem_wdata=0, counters=0, latency counter=0.
- REQ-035: reset asserted mid-operation (any state) SHALL abort the transaction; no strobe or resp_valid after release until a new accept.
- REQ-036: First accept possible on the first rising edge after reset deasserts.

Verification
- REQ-037: MEM_LATENCY=2, req_addr=0x104, req_wb=0, dmem returns 0xDEADBEEF -> dmem_re one cycle with dmem_addr=0x104, resp_valid 4 cycles after accept, resp_data=0xDEADBEEF, refill_cnt=1.
- REQ-038: req_wb=1, wb_addr=0x203, wb_data=0x12345678, req_addr=0x40 -> dmem_we cycle addr=0x200 data=0x12345678, next cycle dmem_re addr=0x40, resp_valid 5 cycles after accept, wb_cnt=1.
- REQ-039: resp_ready low 3 cycles in RESP -> resp_valid/resp_data held, req_ready=0, no new accept despite req_valid=1.
- REQ-040: reset pulsed low during RD_WAIT -> all outputs to reset values asynchronously, stale dmem_rdata never appears on resp_data, counters 0.
- REQ-041: CNT_W=4, 17 back-to-back refills with resp_ready=1 -> refill_cnt stops at 0xF, accepts spaced MEM_LATENCY+3 cycles apart.

Source files
------------

// File: rtl/l2_refill_unit.sv
// L2 miss refill engine: optional dirty-victim writeback, then a single-word read
// from a fixed-latency data memory, returned to the L2 through a valid/ready handshake.
module l2_refill_unit #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_addr_i,
  input  logic             req_wb_i,
  input  logic [31:0]      req_wb_addr_i,
  input  logic [31:0]      req_wb_data_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_data_o,
  output logic [31:0]      dmem_addr_o,
  output logic             dmem_we_o,
  output logic [31:0]      dmem_wdata_o,
  output logic             dmem_re_o,
  input  logic [31:0]      dmem_rdata_i,
  output logic [CNT_W-1:0] refill_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    RD_WAIT,
    RESP
  } state_e;

  localparam logic [3:0] LatInit = 4'(MEM_LATENCY);

  state_e           state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [29:0]      wb_addr_q, wb_addr_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [3:0]       lat_q, lat_d;
  logic [CNT_W-1:0] refill_cnt_q, refill_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  // Byte offsets are dropped: memory is word-addressed and misalignment is not an error.
  logic unused_byte_offsets;
  assign unused_byte_offsets = ^{req_addr_i[1:0], req_wb_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      resp_data_q  <= '0;
      lat_q        <= '0;
      refill_cnt_q <= '0;
      wb_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      resp_data_q  <= resp_data_d;
      lat_q        <= lat_d;
      refill_cnt_q <= refill_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
    end
  end

  // Memory strobes are decoded from state so they drop together with an async reset.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    resp_data_d  = resp_data_q;
    lat_d        = lat_q;
    refill_cnt_d = refill_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_re_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d    = req_addr_i[31:2];
          wb_addr_d = req_wb_addr_i[31:2];
          wb_data_d = req_wb_data_i;
          state_d   = req_wb_i ? WB : RD;
        end
      end
      WB: begin
        dmem_we_o    = 1'b1;
        dmem_addr_o  = {wb_addr_q, 2'b00};
        dmem_wdata_o = wb_data_q;
        if (wb_cnt_q != '1) begin
          wb_cnt_d = wb_cnt_q + CNT_W'(1);
        end
        state_d = RD;
      end
      RD: begin
        dmem_re_o   = 1'b1;
        dmem_addr_o = {addr_q, 2'b00};
        lat_d       = LatInit;
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        lat_d = lat_q - 4'd1;
        // Read data is on the bus in the last counted cycle, MEM_LATENCY after the strobe.
        if (lat_q == 4'd1) begin
          resp_data_d = dmem_rdata_i;
          state_d     = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          if (refill_cnt_q != '1) begin
            refill_cnt_d = refill_cnt_q + CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data_o  = resp_data_q;
  assign refill_cnt_o = refill_cnt_q;
  assign wb_cnt_o     = wb_cnt_q;

endmodule
